// File: rtl/pipe_pkg.sv
// Shared types and boundary widths for the pipeline-stage registers.
//   skid_state_t : occupancy of a skid-buffered stage (empty / main / main+skid)
//   WB_CTRL_W    : control-field width at the write-back boundary
//   WB_DATA_W    : data-field width at the write-back boundary
package pipe_pkg;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'd0,
      SK_ONE   = 2'd1,
      SK_TWO   = 2'd2
   } skid_state_t;

   localparam int unsigned WB_CTRL_W = 4;
   localparam int unsigned WB_DATA_W = 133;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle of one pipeline-stage boundary.
//   in_*      : upstream valid/ready with control and data fields
//   out_*     : downstream valid/ready with control and data fields
//   flush     : synchronous squash of held and incoming entries
//   stall_*   : stall counter and its synchronous clear
// Modports: slave = the stage itself, master = the surrounding logic.
interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W      = WB_CTRL_W,
   parameter int unsigned DATA_W      = WB_DATA_W,
   parameter int unsigned STALL_CNT_W = 16
);

   logic                   in_valid;
   logic                   in_ready;
   logic [CTRL_W-1:0]      in_ctrl;
   logic [DATA_W-1:0]      in_data;
   logic                   flush;
   logic                   out_valid;
   logic                   out_ready;
   logic [CTRL_W-1:0]      out_ctrl;
   logic [DATA_W-1:0]      out_data;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic                   stall_clr;

   modport slave (
      input  in_valid, in_ctrl, in_data, flush, out_ready, stall_clr,
      output in_ready, out_valid, out_ctrl, out_data, stall_cnt
   );

   modport master (
      output in_valid, in_ctrl, in_data, flush, out_ready, stall_clr,
      input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
   );

endinterface : pipe_stage_skid_if

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to zero
//   inc      : increment request, ignored once the count is all-ones
//   cnt      : current count (registered)
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_stage_skid.sv
// One pipeline-stage boundary with valid/ready handshake, a two-entry skid
// buffer, synchronous flush and a saturating stall counter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stage handshake bundle (slave side)
// Bubbles present a zero control field so no write-enable leaks downstream;
// the data field is never cleared and holds its last loaded value.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W      = WB_CTRL_W,
   parameter int unsigned DATA_W      = WB_DATA_W,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stage_skid_if.slave  bus
);

   skid_state_t       state_q;
   logic [CTRL_W-1:0] main_ctrl_q;
   logic [DATA_W-1:0] main_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;

   logic in_ready;
   logic out_valid;
   logic in_xfer;
   logic out_xfer;

   // Handshake flags decode the state register only, so out_ready never
   // reaches in_ready combinationally.
   assign in_ready  = (state_q != SK_TWO);
   assign out_valid = (state_q != SK_EMPTY);
   assign in_xfer   = bus.in_valid & in_ready;
   assign out_xfer  = out_valid & bus.out_ready;

   // Occupancy and entry storage; flush only rewinds the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SK_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else if (bus.flush) begin
         state_q <= SK_EMPTY;
      end else begin
         case (state_q)
            SK_EMPTY: begin
               if (in_xfer) begin
                  state_q     <= SK_ONE;
                  main_ctrl_q <= bus.in_ctrl;
                  main_data_q <= bus.in_data;
               end
            end
            SK_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_ctrl_q <= bus.in_ctrl;
                  main_data_q <= bus.in_data;
               end else if (in_xfer) begin
                  // Downstream stalled: park the newcomer behind main.
                  state_q     <= SK_TWO;
                  skid_ctrl_q <= bus.in_ctrl;
                  skid_data_q <= bus.in_data;
               end else if (out_xfer) begin
                  state_q <= SK_EMPTY;
               end
            end
            SK_TWO: begin
               if (out_xfer) begin
                  state_q     <= SK_ONE;
                  main_ctrl_q <= skid_ctrl_q;
                  main_data_q <= skid_data_q;
               end
            end
            default: begin
               state_q <= SK_EMPTY;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign bus.out_data  = main_data_q;

   // Counts cycles where a held entry is refused downstream.
   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.stall_clr),
      .inc (out_valid & ~bus.out_ready),
      .cnt (bus.stall_cnt)
   );

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a
// randomized run compared against a queue-based occupancy model.
module tb_pipe_stage_skid;

   localparam int unsigned CW = 4;
   localparam int unsigned DW = 133;
   localparam int unsigned SW = 4;
   localparam int SMAX = (1 << SW) - 1;

   logic clk;
   logic rst;

   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(SW)) bus ();

   pipe_stage_skid #(
      .CTRL_W      (CW),
      .DATA_W      (DW),
      .STALL_CNT_W (SW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: FIFO of at most two entries, head drives the outputs.
   logic [CW-1:0] mq_c[$];
   logic [DW-1:0] mq_d[$];
   logic [DW-1:0] m_last;
   int            m_stall;

   function automatic void model_reset();
      mq_c.delete();
      mq_d.delete();
      m_last  = '0;
      m_stall = 0;
   endfunction

   function automatic logic m_valid();
      return mq_d.size() > 0;
   endfunction

   function automatic logic m_ready();
      return mq_d.size() < 2;
   endfunction

   function automatic logic [CW-1:0] m_ctrl();
      return (mq_c.size() > 0) ? mq_c[0] : '0;
   endfunction

   // Advance the model with the inputs currently applied, then clock the DUT.
   task automatic tick();
      logic ov, ir, oxf, ixf;
      logic [CW-1:0] dc;
      logic [DW-1:0] dd;
      ov  = m_valid();
      ir  = m_ready();
      oxf = ov && bus.out_ready;
      ixf = bus.in_valid && ir;
      if (bus.stall_clr) m_stall = 0;
      else if (ov && !bus.out_ready && m_stall < SMAX) m_stall++;
      if (bus.flush) begin
         mq_c.delete();
         mq_d.delete();
      end else begin
         if (oxf) begin
            dc = mq_c.pop_front();
            dd = mq_d.pop_front();
         end
         if (ixf) begin
            mq_c.push_back(bus.in_ctrl);
            mq_d.push_back(bus.in_data);
         end
      end
      if (mq_d.size() > 0) m_last = mq_d[0];
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_ctrl   = '0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      bus.stall_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #23 rst = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
      n_tests++;
      if (bus.out_ctrl !== 4'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %0h expected 0", bus.out_ctrl); end
      n_tests++;
      if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
      n_tests++;
      if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt); end
   endtask

   task automatic test_single();
      bus.in_valid  = 1'b1;
      bus.in_ctrl   = 4'b0101;
      bus.in_data   = DW'(8'hA5);
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", bus.out_valid); end
      n_tests++;
      if (bus.out_ctrl !== 4'b0101) begin n_fail++; $display("FAIL single_ctrl: got %0h expected 5", bus.out_ctrl); end
      n_tests++;
      if (bus.out_data !== DW'(8'hA5)) begin n_fail++; $display("FAIL single_data: got %0h expected a5", bus.out_data); end
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %0b expected 0", bus.out_valid); end
      n_tests++;
      if (bus.out_ctrl !== 4'h0) begin n_fail++; $display("FAIL single_bubble_ctrl: got %0h expected 0", bus.out_ctrl); end
      n_tests++;
      if (bus.out_data !== DW'(8'hA5)) begin n_fail++; $display("FAIL single_data_hold: got %0h expected a5", bus.out_data); end
   endtask

   task automatic test_stream();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_ctrl  = CW'(i);
         bus.in_data  = DW'(i);
         n_tests++;
         if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, bus.in_ready); end
         tick();
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i)) begin
            n_fail++;
            $display("FAIL stream_out[%0d]: got valid=%0b data=%0h expected valid=1 data=%0h", i, bus.out_valid, bus.out_data, i);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      n_tests++;
      if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL stream_stall: got %0d expected 0", bus.stall_cnt); end
   endtask

   task automatic test_skid();
      int            next = 1;
      int            nz   = 0;
      logic          acc;
      logic [DW-1:0] got[$];
      for (int c = 0; c < 20; c++) begin
         bus.out_ready = (c != 2);
         bus.in_valid  = (next <= 4);
         bus.in_ctrl   = CW'(next);
         bus.in_data   = DW'(next);
         if (!bus.in_ready) nz++;
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) next++;
      end
      bus.in_valid = 1'b0;
      n_tests++;
      if (nz != 1) begin n_fail++; $display("FAIL skid_in_ready_low: got %0d cycles expected 1", nz); end
      n_tests++;
      if (got.size() != 4) begin n_fail++; $display("FAIL skid_count: got %0d entries expected 4", got.size()); end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         n_tests++;
         if (got[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL skid_order[%0d]: got %0h expected %0h", i, got[i], i + 1); end
      end
      n_tests++;
      if (bus.stall_cnt !== SW'(1)) begin n_fail++; $display("FAIL skid_stall: got %0d expected 1", bus.stall_cnt); end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_ctrl   = 4'hF;
      bus.in_data   = DW'(10);
      tick();
      bus.in_data = DW'(11);
      tick();
      n_tests++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got in_ready=%0b expected 0", bus.in_ready); end
      bus.flush   = 1'b1;
      bus.in_data = DW'(12);
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", bus.out_valid); end
      n_tests++;
      if (bus.out_ctrl !== 4'h0) begin n_fail++; $display("FAIL flush_ctrl: got %0h expected 0", bus.out_ctrl); end
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %0b expected 1", bus.in_ready); end
      n_tests++;
      if (bus.out_data !== DW'(10)) begin n_fail++; $display("FAIL flush_data_hold: got %0h expected a", bus.out_data); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got valid=%0b data=%0h expected valid=0", i, bus.out_valid, bus.out_data); end
      end
   endtask

   task automatic test_saturate();
      bus.stall_clr = 1'b1;
      tick();
      bus.stall_clr = 1'b0;
      n_tests++;
      if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL sat_pre_clear: got %0d expected 0", bus.stall_cnt); end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_ctrl   = 4'h3;
      bus.in_data   = DW'(8'h55);
      tick();
      bus.in_valid = 1'b0;
      repeat (20) tick();
      n_tests++;
      if (bus.stall_cnt !== SW'(SMAX)) begin n_fail++; $display("FAIL sat_value: got %0d expected %0d", bus.stall_cnt, SMAX); end
      n_tests++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_held: got valid=%0b expected 1", bus.out_valid); end
      bus.stall_clr = 1'b1;
      tick();
      bus.stall_clr = 1'b0;
      n_tests++;
      if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL sat_clear: got %0d expected 0", bus.stall_cnt); end
      bus.out_ready = 1'b1;
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain: got valid=%0b expected 0", bus.out_valid); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_ctrl   = 4'h9;
      bus.in_data   = DW'(20);
      tick();
      bus.in_data = DW'(21);
      tick();
      bus.in_valid = 1'b0;
      n_tests++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_full: got in_ready=%0b expected 0", bus.in_ready); end
      rst = 1'b1;
      #1;
      model_reset();
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0b expected 0", bus.out_valid); end
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %0b expected 1", bus.in_ready); end
      n_tests++;
      if (bus.out_ctrl !== 4'h0 || bus.stall_cnt !== '0) begin
         n_fail++;
         $display("FAIL areset_ctrl_stall: got ctrl=%0h stall=%0d expected 0/0", bus.out_ctrl, bus.stall_cnt);
      end
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_ctrl   = 4'h6;
      bus.in_data   = DW'(7);
      tick();
      bus.in_valid = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(7) || bus.out_ctrl !== 4'h6) begin
         n_fail++;
         $display("FAIL areset_first: got valid=%0b ctrl=%0h data=%0h expected 1/6/7", bus.out_valid, bus.out_ctrl, bus.out_data);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_ctrl   = CW'($urandom());
         bus.in_data   = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 19) == 0);
         bus.stall_clr = ($urandom_range(0, 29) == 0);
         tick();
         n_tests++;
         if (bus.out_valid !== m_valid() || bus.in_ready !== m_ready()) begin
            n_fail++;
            $display("FAIL rand_flags[%0d]: got valid=%0b ready=%0b expected %0b/%0b", c, bus.out_valid, bus.in_ready, m_valid(), m_ready());
         end
         n_tests++;
         if (bus.out_ctrl !== m_ctrl()) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %0h expected %0h", c, bus.out_ctrl, m_ctrl()); end
         n_tests++;
         if (bus.out_data !== m_last) begin n_fail++; $display("FAIL rand_data[%0d]: got %0h expected %0h", c, bus.out_data, m_last); end
         n_tests++;
         if (bus.stall_cnt !== SW'(m_stall)) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", c, bus.stall_cnt, m_stall); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_skid();
      test_flush();
      test_saturate();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pipe_stage_skid

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register that replaces the fixed, free-running inter-stage registers (IF/ID through MEM/WB) of the SIMD AES core. It carries a control field and a data field across one stage boundary with a valid/ready handshake, a two-entry skid buffer, and a synchronous flush that inserts bubbles. Bubbles have their control field forced to zero so that no write-enable reaches write-back. A saturating stall counter supports performance debug.

## Interface
- CTRL_W, 4: control-field width (RegWrite, VRegWrite, MemToReg[1:0] for the write-back boundary); zeroed on bubbles
- DATA_W, 133: data-field width (e.g. MemData, ALUResult, sbox, rcon, rd); never zeroed
- STALL_CNT_W, 16: stall-counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream data field
- flush  in  1  synchronous squash of all held and incoming entries
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  held control; 0 whenever out_valid=0
- out_data  out  DATA_W  held data
- stall_cnt  out  STALL_CNT_W  cycles with out_valid & !out_ready; saturating
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Storage: main entry (drives outputs) and skid entry.
- States: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- EMPTY: in_xfer -> ONE, main <= in.
- ONE: in_xfer & out_xfer -> ONE, main <= in. in_xfer & !out_xfer -> TWO, skid <= in. !in_xfer & out_xfer -> EMPTY. Otherwise hold.
- TWO: out_xfer -> ONE, main <= skid. in_ready=0, so the input is ignored.
- in_ready = (state != TWO), taken from the state register. There is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). out_ctrl = out_valid ? main.ctrl : 0.
- out_data holds its last loaded value when the stage is empty. It is not cleared.
- flush has top priority. Next state is EMPTY, and any entry presented on the flush cycle is dropped. Data registers are left unchanged.
- stall_cnt: stall_clr sets it to 0. Otherwise it increments when out_valid & !out_ready and saturates at all-ones. A flush does not affect stall_cnt.

## Timing
- Reset values: state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, skid=0.
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle) when the stage was EMPTY or draining.
- Throughput: one entry per cycle while out_ready=1. The skid buffer absorbs a single-cycle out_ready drop with no lost entry.
- Simultaneous flush and in_xfer: the input is dropped. Simultaneous flush and out_xfer: the downstream consumes the current entry; the next state is EMPTY.
- Reset asserted mid-operation: all entries are discarded immediately (asynchronous). The first accept is possible on the first edge after release.
- Ordering: entries leave in acceptance order. The skid entry always leaves after the main entry.

## Structure
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {SK_EMPTY, SK_ONE, SK_TWO}
  - boundary width constants: WB_CTRL_W=4, WB_DATA_W=133
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, cnt) implements stall_cnt.
- The stage itself is a single always_ff with async reset for state/entries, plus combinational output assignments.

## Test plan
- Reset then a single entry: in_valid=1, ctrl=4'b0101, data=133'hA5 for one cycle, out_ready=1 -> out_valid=1 with ctrl=4'b0101 and data=A5 one cycle later, then out_valid=0 and out_ctrl=0.
- Streaming: 8 entries (data 1..8) with out_ready=1 -> outputs 1..8 on 8 consecutive cycles; in_ready stays 1 and stall_cnt stays 0.
- Skid: stream data 1..4 and drop out_ready for cycle 2 only -> in_ready=0 for exactly one cycle, output order 1,2,3,4, stall_cnt=1.
- Flush in TWO: fill with 10,11 under backpressure, then flush=1 with in_valid=1 and data=12 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 12 never appears.
- Saturation with STALL_CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15; stall_clr -> 0.
- Async reset mid-stream: assert rst between edges while in TWO -> out_valid=0 and in_ready=1 immediately; after release, a new entry with data=7 emerges one cycle after acceptance.
